// File: rtl/cancid_stream_ctx_engine.sv
// Per-stream DFA context engine: saves/restores DFA state per stream ID, drains the DFA at end-of-packet and keeps match counters.
// Optional `CANCID_CNT_SAT_EN: per-stream and total counters saturate instead of wrapping.
module cancid_stream_ctx_engine #(
  parameter int STATE_W     = 11,
  parameter int NUM_STREAMS = 64,
  parameter int SID_W       = 6,
  parameter int CNT_W       = 16,
  parameter int DFA_LAT     = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sop,
  input  logic [SID_W-1:0]   sid,
  input  logic               enable,
  input  logic [7:0]         char_in,
  input  logic               char_vld,
  input  logic               eop,
  output logic               ready,
  input  logic               flush,
  input  logic [SID_W-1:0]   flush_sid,
  output logic [7:0]         dfa_char,
  output logic               dfa_char_vld,
  output logic [STATE_W-1:0] dfa_state_in,
  output logic               dfa_state_in_vld,
  input  logic [STATE_W-1:0] dfa_state_out,
  input  logic               dfa_accept,
  output logic               fired,
  output logic               commit_vld,
  input  logic [SID_W-1:0]   rd_sid,
  output logic [CNT_W-1:0]   rd_count,
  output logic [CNT_W-1:0]   total_count
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, COMMIT} state_t;

  localparam int DCNT_W = $clog2(DFA_LAT + 2) + 1;
  localparam logic [SID_W:0] NS = (SID_W+1)'(NUM_STREAMS);

  state_t               state, state_nx;
  logic [SID_W-1:0]     sid_q;
  logic                 en_q;
  logic                 fired_q;
  logic [DCNT_W-1:0]    drain_cnt;
  logic [STATE_W-1:0]   st_q;
  logic [NUM_STREAMS-1:0] valid;
  logic [STATE_W-1:0]   state_mem [NUM_STREAMS];
  logic [CNT_W-1:0]     cnt       [NUM_STREAMS];
  logic                 sid_ok, flush_ok, rd_ok, do_commit;

  assign sid_ok    = {1'b0, sid_q} < NS;
  assign flush_ok  = {1'b0, flush_sid} < NS;
  assign rd_ok     = {1'b0, rd_sid} < NS;
  assign do_commit = (state == COMMIT) && en_q && sid_ok;
  assign fired     = fired_q;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v, input logic inc);
`ifdef CANCID_CNT_SAT_EN
    bump = (inc && (v != '1)) ? v + 1'b1 : v;
`else
    bump = v + CNT_W'(inc);
`endif
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (sop) state_nx = LOAD;
      LOAD:    state_nx = RUN;
      RUN:     if (eop) state_nx = DRAIN;
      DRAIN:   if (drain_cnt == '0) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ready            = 1'b0;
    dfa_state_in     = '0;
    dfa_state_in_vld = 1'b0;
    commit_vld       = 1'b0;
    case (state)
      IDLE, RUN: ready = 1'b1;
      LOAD: begin
        dfa_state_in_vld = 1'b1;
        if (sid_ok && valid[sid_q]) dfa_state_in = state_mem[sid_q];
      end
      COMMIT:  commit_vld = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sid_q        <= '0;
      en_q         <= 1'b0;
      fired_q      <= 1'b0;
      drain_cnt    <= '0;
      st_q         <= '0;
      dfa_char     <= '0;
      dfa_char_vld <= 1'b0;
      valid        <= '0;
      total_count  <= '0;
      rd_count     <= '0;
      for (int unsigned i = 0; i < NUM_STREAMS; i++) cnt[i] <= '0;
    end else begin
      st_q         <= dfa_state_out;
      dfa_char_vld <= (state == RUN) && char_vld;
      if ((state == RUN) && char_vld) dfa_char <= char_in;
      // Read port samples before this cycle's COMMIT write lands.
      rd_count <= rd_ok ? cnt[rd_sid] : '0;
      case (state)
        IDLE: begin
          if (sop) begin
            sid_q   <= sid;
            en_q    <= enable;
            fired_q <= 1'b0;
          end else if (flush && flush_ok) begin
            valid[flush_sid] <= 1'b0;
          end
        end
        RUN: begin
          if (dfa_accept) fired_q <= 1'b1;
          if (eop) drain_cnt <= DCNT_W'(DFA_LAT + 1);
        end
        DRAIN: begin
          if (dfa_accept) fired_q <= 1'b1;
          if (drain_cnt != '0) drain_cnt <= drain_cnt - 1'b1;
        end
        COMMIT: begin
          if (!en_q) fired_q <= 1'b0;
          if (do_commit) begin
            valid[sid_q] <= 1'b1;
            cnt[sid_q]   <= bump(cnt[sid_q], fired_q);
            total_count  <= bump(total_count, fired_q);
          end
        end
        default: ;
      endcase
    end
  end

  // Context memory is unreset; the valid bitmap gates its contents.
  always_ff @(posedge clk) begin
    if (do_commit) state_mem[sid_q] <= st_q;
  end

endmodule

// File: tb/tb_cancid_stream_ctx_engine.sv
// Scoreboard bench for cancid_stream_ctx_engine with an "abc" matching DFA model of latency 3.
module tb_cancid_stream_ctx_engine;
  localparam int STATE_W = 11, NUM_STREAMS = 48, SID_W = 6, CNT_W = 4, DFA_LAT = 3;

  logic clk = 1'b0, rst = 1'b1;
  logic sop = 0, enable = 0, char_vld = 0, eop = 0, flush = 0;
  logic [SID_W-1:0] sid = '0, flush_sid = '0, rd_sid = '0;
  logic [7:0] char_in = '0, dfa_char;
  logic ready, dfa_char_vld, dfa_state_in_vld, dfa_accept, fired, commit_vld;
  logic [STATE_W-1:0] dfa_state_in, dfa_state_out;
  logic [CNT_W-1:0] rd_count, total_count;

  always #5 clk = ~clk;

  cancid_stream_ctx_engine #(.STATE_W(STATE_W), .NUM_STREAMS(NUM_STREAMS), .SID_W(SID_W),
                             .CNT_W(CNT_W), .DFA_LAT(DFA_LAT)) dut (
    .clk(clk), .rst(rst), .sop(sop), .sid(sid), .enable(enable), .char_in(char_in),
    .char_vld(char_vld), .eop(eop), .ready(ready), .flush(flush), .flush_sid(flush_sid),
    .dfa_char(dfa_char), .dfa_char_vld(dfa_char_vld), .dfa_state_in(dfa_state_in),
    .dfa_state_in_vld(dfa_state_in_vld), .dfa_state_out(dfa_state_out), .dfa_accept(dfa_accept),
    .fired(fired), .commit_vld(commit_vld), .rd_sid(rd_sid), .rd_count(rd_count),
    .total_count(total_count));

  int n_chk = 0, n_bad = 0;
  task automatic check(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [STATE_W-1:0] dfa_next(input logic [STATE_W-1:0] s, input logic [7:0] c);
    if (c == 8'h61) return STATE_W'(1);
    if (s == STATE_W'(1) && c == 8'h62) return STATE_W'(2);
    if (s == STATE_W'(2) && c == 8'h63) return STATE_W'(3);
    return '0;
  endfunction

  // External DFA: state register plus two delay stages for a total latency of 3.
  logic [STATE_W-1:0] cur = '0, p1 = '0, p2 = '0;
  logic acc = 0, a1 = 0, a2 = 0;
  always @(posedge clk) begin
    if (dfa_state_in_vld) begin
      cur <= dfa_state_in; acc <= 1'b0;
    end else if (dfa_char_vld) begin
      cur <= dfa_next(cur, dfa_char);
      acc <= (dfa_next(cur, dfa_char) == STATE_W'(3));
    end else acc <= 1'b0;
    p1 <= cur; a1 <= acc; p2 <= p1; a2 <= a1;
  end
  assign dfa_state_out = p2;
  assign dfa_accept    = a2;

  bit                 mvalid [64];
  logic [STATE_W-1:0] mstate [64];
  logic [CNT_W-1:0]   mcnt   [64];
  logic [CNT_W-1:0]   mtot;

  function automatic logic [CNT_W-1:0] m_inc(input logic [CNT_W-1:0] v);
`ifdef CANCID_CNT_SAT_EN
    return (v == {CNT_W{1'b1}}) ? v : CNT_W'(v + 1);
`else
    return CNT_W'(v + 1);
`endif
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 64; i++) begin mvalid[i] = 0; mstate[i] = '0; mcnt[i] = '0; end
    mtot = '0;
  endtask

  typedef struct { bit f; bit en; logic [CNT_W-1:0] tot; } cexp_t;
  cexp_t cq[$];
  logic [STATE_W-1:0] lq[$];
  int cyc = 0, eop_cyc = 0, ncommit = 0;
  bit pend = 0;
  cexp_t pe;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (pend) begin
      check("total_count", total_count, pe.tot);
      check("fired_after_commit", fired, pe.en ? pe.f : 1'b0);
      pend = 0;
    end
    if (dfa_state_in_vld) begin
      if (lq.size() == 0) check("load_unexpected", 1, 0);
      else check("load_state", dfa_state_in, lq.pop_front());
    end
    if (commit_vld) begin
      ncommit++;
      if (cq.size() == 0) check("commit_unexpected", 1, 0);
      else begin
        pe = cq.pop_front();
        check("fired_at_commit", fired, pe.f);
        check("eop_to_commit", cyc - eop_cyc, DFA_LAT + 3);
        pend = 1;
      end
    end
  end

  logic [7:0] pkt[$];
  task automatic set_pkt(input string str);
    pkt.delete();
    for (int i = 0; i < str.len(); i++) pkt.push_back(str[i]);
  endtask

  task automatic send(input int s, input bit en, input bit fl, input int fsid);
    logic [STATE_W-1:0] st;
    bit f;
    int c0;
    for (int k = 0; k < 50 && !ready; k++) @(posedge clk) #1;
    check("ready_idle", ready, 1);
    st = (s < NUM_STREAMS && mvalid[s]) ? mstate[s] : '0;
    lq.push_back(st);
    f = 0;
    foreach (pkt[i]) begin
      st = dfa_next(st, pkt[i]);
      if (st == STATE_W'(3)) f = 1;
    end
    if (en && s < NUM_STREAMS) begin
      mvalid[s] = 1; mstate[s] = st;
      if (f) begin mcnt[s] = m_inc(mcnt[s]); mtot = m_inc(mtot); end
    end
    cq.push_back('{f, en, mtot});
    c0 = ncommit;
    sop = 1; sid = SID_W'(s); enable = en; flush = fl; flush_sid = SID_W'(fsid);
    @(posedge clk) #1;
    sop = 0; flush = 0;
    @(posedge clk) #1;
    if (pkt.size() == 0) begin
      eop = 1; eop_cyc = cyc;
      @(posedge clk) #1;
    end else begin
      foreach (pkt[i]) begin
        char_vld = 1; char_in = pkt[i]; eop = (i == pkt.size() - 1);
        if (eop) eop_cyc = cyc;
        @(posedge clk) #1;
      end
    end
    char_vld = 0; eop = 0;
    for (int k = 0; k < 100 && ncommit == c0; k++) @(posedge clk) #1;
    if (ncommit == c0) check("commit_timeout", 0, 1);
    rd_sid = SID_W'(s);
    @(posedge clk) #1;
    @(posedge clk) #1;
    if (s < NUM_STREAMS) check("rd_count", rd_count, mcnt[s]);
  endtask

  task automatic do_flush(input int s);
    flush = 1; flush_sid = SID_W'(s);
    @(posedge clk) #1;
    flush = 0;
    if (s < NUM_STREAMS) mvalid[s] = 0;
  endtask

  task automatic read_cnt(input int s);
    rd_sid = SID_W'(s);
    @(posedge clk) #1;
    @(posedge clk) #1;
    check("rd_count_post_reset", rd_count, mcnt[s]);
  endtask

  initial begin
    int c0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("rst_commit_vld", commit_vld, 0);
    check("rst_fired", fired, 0);
    check("rst_dfa_char_vld", dfa_char_vld, 0);
    check("rst_state_in_vld", dfa_state_in_vld, 0);
    check("rst_total", total_count, 0);
    check("rst_rd_count", rd_count, 0);
    rst = 0;
    @(posedge clk) #1;

    set_pkt("abca"); send(5, 1, 0, 0);   // new stream, ends mid-pattern
    set_pkt("bcxa"); send(5, 1, 0, 0);   // resume: split match fires
    set_pkt("abc");  send(7, 0, 0, 0);   // disabled stream
    set_pkt("x");    send(7, 1, 0, 0);   // still invalid -> loads 0
    do_flush(5);
    set_pkt("");     send(5, 1, 0, 0);   // empty packet after flush
    set_pkt("ab");   send(9, 1, 0, 0);
    set_pkt("c");    send(9, 1, 1, 9);   // flush with sop is dropped
    set_pkt("xxabc"); send(10, 1, 0, 0); // accept on final byte only
    set_pkt("ab");   send(50, 1, 0, 0);  // out-of-range sid
    set_pkt("c");    send(50, 1, 0, 0);
    set_pkt("abc");
    for (int n = 0; n < 16; n++) send(1, 1, 0, 0);

    // Reset mid-RUN aborts the packet and clears all contexts.
    lq.push_back('0);
    c0 = ncommit;
    sop = 1; sid = SID_W'(3); enable = 1;
    @(posedge clk) #1;
    sop = 0;
    @(posedge clk) #1;
    char_vld = 1; char_in = 8'h61;
    @(posedge clk) #1;
    char_in = 8'h62;
    @(posedge clk) #1;
    char_vld = 0;
    rst = 1;
    @(posedge clk) #1;
    rst = 0;
    model_clear();
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_commit", ncommit, c0);
    check("abort_total", total_count, 0);
    read_cnt(1);
    read_cnt(5);
    set_pkt("a"); send(5, 1, 0, 0);      // context invalidated -> loads 0

    check("queues_empty", cq.size() + lq.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cancid_stream_ctx_engine.md
Name: cancid_stream_ctx_engine

Overview:
- Parametrised per-stream context engine for one regex DFA in the packet-inspection DPI core.
- Saves and restores DFA state per stream ID.
- Drains the DFA pipeline before committing at end-of-packet.
- Keeps a per-stream match count and a global match count.
- Supersedes the fixed 64-stream, 11-bit, single-counter category wrapper.
- The DFA is external and attaches through the dfa_* ports; this lets one engine serve any category DFA.

Parameters:
STATE_W, 11, DFA state width
NUM_STREAMS, 64, number of stream contexts
SID_W, 6, stream ID width; must satisfy 2**SID_W >= NUM_STREAMS
CNT_W, 16, width of per-stream and total counters
DFA_LAT, 1, cycles from dfa_char_vld to the matching dfa_state_out/dfa_accept

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
sop  in  1  start of packet; accepted only when ready=1 in IDLE
sid  in  SID_W  stream ID; sampled with sop
enable  in  1  regex enabled for this stream; sampled with sop
char_in  in  8  packet byte
char_vld  in  1  byte valid; accepted when ready=1 in RUN
eop  in  1  last beat of packet; qualified in RUN; may occur with or without char_vld
ready  out  1  engine accepts sop (IDLE) or bytes (RUN)
flush  in  1  invalidate context of flush_sid; honoured only in IDLE
flush_sid  in  SID_W  stream to invalidate
dfa_char  out  8  registered byte to DFA
dfa_char_vld  out  1  registered byte valid
dfa_state_in  out  STATE_W  state to load
dfa_state_in_vld  out  1  load strobe, one cycle
dfa_state_out  in  STATE_W  DFA current state
dfa_accept  in  1  DFA accept flag
fired  out  1  speculative match seen in current packet
commit_vld  out  1  one-cycle pulse when packet committed
rd_sid  in  SID_W  per-stream count read address
rd_count  out  CNT_W  count of rd_sid; registered, 1-cycle latency
total_count  out  CNT_W  sum of all committed matches

Behaviour:
- Reset: all outputs 0; FSM in IDLE; stream-valid bitmap cleared; all per-stream counts = 0; total_count = 0. State memory contents are don't-care; they are gated by the valid bit.
- FSM states: IDLE, LOAD, RUN, DRAIN, COMMIT.
- IDLE:
  - ready=1.
  - sop: capture sid and enable, clear fired, go to LOAD.
  - Otherwise, flush: clear valid[flush_sid].
  - sop has priority over flush; a flush in the same cycle is dropped.
- LOAD (1 cycle):
  - ready=0.
  - dfa_state_in = valid[sid] ? state_mem[sid] : 0.
  - dfa_state_in_vld=1.
  - Go to RUN.
- RUN:
  - ready=1.
  - Each char_vld registers char_in to dfa_char with dfa_char_vld one cycle later.
  - On eop, with or without a byte, go to DRAIN with drain counter = DFA_LAT+1.
- DRAIN:
  - ready=0.
  - Counter decrements each cycle; at 0 go to COMMIT.
  - This guarantees the last byte's dfa_state_out and dfa_accept have been sampled.
- fired: set whenever registered dfa_accept=1 during RUN or DRAIN. It is sticky until the next sop.
- COMMIT (1 cycle):
  - commit_vld=1.
  - If enable: state_mem[sid] <= registered dfa_state_out; valid[sid] <= 1; count[sid] += fired; total_count += fired.
  - If not enable: no memory, count or valid update; fired forced to 0 on the next cycle.
  - Go to IDLE.
- A packet with zero bytes (eop alone) still loads, drains and commits. The saved state equals the loaded state.
- Counter overflow wraps modulo 2**CNT_W, unless the optional feature is enabled.
- rd_count reflects COMMIT writes from the cycle after COMMIT. A read of the same sid during COMMIT returns the old value.
- sid >= NUM_STREAMS is treated as not valid: state loads as 0, and COMMIT writes nothing.
- rst mid-packet aborts the packet: no commit, all contexts invalidated.

Optional Feature:
- Macro: CANCID_CNT_SAT_EN.
- Defined: per-stream and total counters saturate at 2**CNT_W-1; an increment at max holds max.
- Undefined: counters wrap to 0.

Test Plan:
- New stream: sid=5, enable=1, bytes that make DFA accept on byte 3 of 4 -> dfa_state_in=0 in LOAD, fired=1 from one cycle after the accept, commit_vld pulse, rd_count(5)=1, total_count=1.
- Resume: second packet on sid=5 -> dfa_state_in equals state saved at the prior COMMIT; a match split across the two packets fires; rd_count(5)=2.
- Disabled: sid=7, enable=0, accepting payload -> fired goes high during packet, count[7]=0, valid[7] stays 0, total_count unchanged.
- Flush and empty packet: flush sid=5 in IDLE, then sop+eop with no bytes on sid=5 -> LOAD drives 0, COMMIT saves 0, commit_vld=1.
- Drain timing: DFA_LAT=3, accept only on the final byte -> fired=1 and counted; commit_vld occurs exactly DFA_LAT+3 cycles after the eop beat.
- Overflow: CNT_W=4, 16 matching packets on sid=1 -> rd_count=0 without CANCID_CNT_SAT_EN; rd_count=15 with it. Assert rst mid-RUN -> no commit_vld, all counts 0.
